// File: rtl/adsr_vca.sv
// ADSR envelope generator plus VCA: scales the VCO sample by a gated envelope once per sample tick.
// Optional build macro ADSR_EXP_RELEASE_EN selects an exponential release instead of the linear one.
module adsr_vca #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic        gate,
  input  logic [9:0]  attack_rate,
  input  logic [9:0]  decay_rate,
  input  logic [9:0]  sustain_level,
  input  logic [9:0]  release_rate,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic [15:0] env_out,
  output logic [2:0]  env_state,
  output logic        active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   gate_prev_q, gate_prev_d;
  logic [15:0]            env_q, env_d;
  logic [15:0]            d_out_q, d_out_d;

  logic        gate_s, rise, fall;
  logic [15:0] sus_t;
  logic [16:0] a_step, d_step, r_step, a_sum, t_plus_d;
  logic [15:0] prod_hi;

  assign gate_s   = sync_q[SYNC_STAGES-1];
  assign rise     = gate_s & ~gate_prev_q;
  assign fall     = ~gate_s & gate_prev_q;
  // Replicating the top bits makes 0x3FF land exactly on full scale.
  assign sus_t    = {sustain_level, sustain_level[9:4]};
  assign a_step   = {7'd0, attack_rate} + 17'd1;
  assign d_step   = {7'd0, decay_rate} + 17'd1;
`ifdef ADSR_EXP_RELEASE_EN
  assign r_step   = {1'b0, env_q >> 5} + 17'd1;
`else
  assign r_step   = {7'd0, release_rate} + 17'd1;
`endif
  assign a_sum    = {1'b0, env_q} + a_step;
  assign t_plus_d = {1'b0, sus_t} + d_step;
  assign prod_hi  = 16'((32'(d_in) * 32'(env_q)) >> 16);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], gate};
    state_d     = state_q;
    env_d       = env_q;
    gate_prev_d = gate_prev_q;
    d_out_d     = d_out_q;
    if (sample_tick) begin
      gate_prev_d = gate_s;
      d_out_d     = prod_hi;
      if (rise) begin
        state_d = ATTACK;
      end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        unique case (state_q)
          IDLE: env_d = 16'd0;
          ATTACK: begin
            if (a_sum >= 17'h0FFFF) begin
              env_d   = 16'hFFFF;
              state_d = DECAY;
            end else begin
              env_d = a_sum[15:0];
            end
          end
          DECAY: begin
            if ({1'b0, env_q} <= t_plus_d) begin
              env_d   = sus_t;
              state_d = SUSTAIN;
            end else begin
              env_d = env_q - d_step[15:0];
            end
          end
          SUSTAIN: env_d = sus_t;
          RELEASE: begin
            if ({1'b0, env_q} <= r_step) begin
              env_d   = 16'd0;
              state_d = IDLE;
            end else begin
              env_d = env_q - r_step[15:0];
            end
          end
          default: begin
            env_d   = 16'd0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      env_q       <= 16'd0;
      gate_prev_q <= 1'b0;
      d_out_q     <= 16'd0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      env_q       <= env_d;
      gate_prev_q <= gate_prev_d;
      d_out_q     <= d_out_d;
    end
  end

  assign d_out     = d_out_q;
  assign env_out   = env_q;
  assign env_state = state_q;
  assign active    = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_vca.sv
// Directed bench for adsr_vca: reset, attack/decay/sustain, release, retrigger, VCA math, tick gating.
module tb_adsr_vca;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        gate = 1'b0;
  logic [9:0]  attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out, env_out;
  logic [2:0]  env_state;
  logic        active;

  int n_cmp = 0;
  int n_bad = 0;

  adsr_vca #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
    .release_rate(release_rate), .d_in(d_in), .d_out(d_out), .env_out(env_out),
    .env_state(env_state), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // n back-to-back ticks; outputs are sampled 1 time unit after the last edge
  task automatic tick(input int n);
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic set_gate(input logic v);
    @(negedge clk);
    gate = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] prev_env;
    logic        mono;
    int          guard;

    #3;
    chk("rst_env", env_out, 0);
    chk("rst_state", env_state, 0);
    chk("rst_active", active, 0);
    chk("rst_dout", d_out, 0);
    @(negedge clk) reset_n = 1'b1;

    // Attack with A=512 to reach env=0x8000 for the 0x8000*0x8000 product
    attack_rate = 10'h1FF; decay_rate = 10'h0FF; sustain_level = 10'h200; release_rate = 10'h3FF;
    d_in = 16'h8000;
    set_gate(1'b1);
    tick(1);
    chk("a1_state", env_state, 1);
    chk("a1_env", env_out, 0);
    chk("amp_env0", d_out, 0);
    tick(64);
    chk("a1_env64", env_out, 16'h8000);
    tick(1);
    chk("amp_half", d_out, 16'h4000);
    chk("a1_env65", env_out, 16'h8200);

    // Asynchronous reset mid-attack
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_env", env_out, 0);
    chk("mid_rst_state", env_state, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_dout", d_out, 0);
    @(negedge clk) reset_n = 1'b1;

    // Gate still high: a fresh rising edge after reset restarts attack from 0
    attack_rate = 10'h3FF;
    d_in = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    tick(1);
    chk("a2_state", env_state, 1);
    chk("a2_env", env_out, 0);
    tick(63);
    chk("a2_env63", env_out, 16'hFC00);
    chk("a2_state63", env_state, 1);
    tick(1);
    chk("a2_env64", env_out, 16'hFFFF);
    chk("a2_state64", env_state, 2);
    chk("amp_fc00", d_out, 16'hFBFF);
    tick(1);
    chk("d_env1", env_out, 16'hFEFF);
    chk("amp_full", d_out, 16'hFFFE);
    tick(126);
    chk("d_env127", env_out, 16'h80FF);
    chk("d_state127", env_state, 2);
    tick(1);
    chk("sus_env", env_out, 16'h8020);
    chk("sus_state", env_state, 3);
    chk("amp_80ff", d_out, 16'h80FE);
    sustain_level = 10'h3FF;
    tick(1);
    chk("sus_track_full", env_out, 16'hFFFF);
    sustain_level = 10'h200;
    tick(1);
    chk("sus_track_back", env_out, 16'h8020);

    // Release from 0x8020 with R=1024
    set_gate(1'b0);
    tick(1);
    chk("r_state", env_state, 4);
    chk("r_env0", env_out, 16'h8020);
    tick(1);
`ifdef ADSR_EXP_RELEASE_EN
    chk("r_env1", env_out, 16'h7C1E);
    mono = 1'b1;
    guard = 0;
    while (env_state == 3'd4 && guard < 2000) begin
      prev_env = env_out;
      tick(1);
      if (env_out >= prev_env) mono = 1'b0;
      guard++;
    end
    chk("r_monotonic", 32'(mono), 1);
`else
    chk("r_env1", env_out, 16'h7C20);
    tick(31);
    chk("r_env32", env_out, 16'h0020);
    chk("r_state32", env_state, 4);
    tick(1);
`endif
    chk("r_end_env", env_out, 0);
    chk("r_end_state", env_state, 0);
    chk("r_end_active", active, 0);

    // Retrigger during release continues from the current envelope
    set_gate(1'b1);
    tick(1);
    tick(16);
    chk("rt_env_att", env_out, 16'h4000);
    set_gate(1'b0);
    tick(1);
    chk("rt_rel_state", env_state, 4);
    chk("rt_rel_env", env_out, 16'h4000);
    set_gate(1'b1);
    tick(1);
    chk("rt_state", env_state, 1);
    chk("rt_env", env_out, 16'h4000);
    tick(1);
    chk("rt_env_step", env_out, 16'h4400);
    chk("rt_amp", d_out, 16'h3FFF);

    // No ticks for 1000 cycles while gate toggles; ends high again
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (i % 7 == 0) gate = ~gate;
    end
    gate = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("tg_env", env_out, 16'h4400);
    chk("tg_dout", d_out, 16'h3FFF);
    chk("tg_state", env_state, 1);
    tick(1);
    chk("tg_env_next", env_out, 16'h4800);
    chk("tg_state_next", env_state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule
